// File: rtl/counter_pkg.sv
// Shared counter constants: direction encoding and default count width.
package counter_pkg;

    localparam logic DIR_UP        = 1'b1;
    localparam logic DIR_DOWN      = 1'b0;
    localparam int   CNT_WIDTH_DEF = 8;

endpackage : counter_pkg

// File: rtl/param_counter.sv
// Modulo up/down counter with clear, clamped load and a terminal-event Wrap pulse.
// Define PARAM_COUNTER_SAT_EN to saturate at the terminal value instead of wrapping.
module param_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH   = CNT_WIDTH_DEF,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             ClkEnable,
    input  logic             Clear,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    input  logic             Up,
    output logic [WIDTH-1:0] Count,
    output logic             Wrap,
    output logic             AtTerminal
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] terminal_val;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] wrap_target;
    logic             at_terminal;

    assign terminal_val = (Up == DIR_UP) ? MAX_VAL : '0;
    assign at_terminal  = (count_q == terminal_val);
    assign load_clamped = (LoadValue > MAX_VAL) ? MAX_VAL : LoadValue;

`ifdef PARAM_COUNTER_SAT_EN
    assign wrap_target = count_q;
`else
    assign wrap_target = (Up == DIR_UP) ? '0 : MAX_VAL;
`endif

    always_comb begin
        // NOTE: defaults first so every path assigns count_d/wrap_d and no latch is inferred.
        count_d = count_q;
        wrap_d  = 1'b0;
        if (Clear) begin
            count_d = '0;
        end else if (Load) begin
            count_d = load_clamped;
        end else if (ClkEnable) begin
            wrap_d = at_terminal;
            if (at_terminal) begin
                count_d = wrap_target;
            end else if (Up == DIR_UP) begin
                count_d = count_q + WIDTH'(1);
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    // NOTE: non-blocking assignments so all state updates see pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign Count      = count_q;
    assign Wrap       = wrap_q;
    assign AtTerminal = at_terminal;

endmodule : param_counter

// File: tb/tb_param_counter.sv
// Directed self-checking bench for param_counter at WIDTH=4, MODULUS=10.
module tb_param_counter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             clk_enable;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             up;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             at_terminal;

    int checks   = 0;
    int failures = 0;

    param_counter #(.WIDTH(WIDTH), .MODULUS(10)) dut (
        .Clk        (clk),
        .Rst        (rst),
        .ClkEnable  (clk_enable),
        .Clear      (clear),
        .Load       (load),
        .LoadValue  (load_value),
        .Up         (up),
        .Count      (count),
        .Wrap       (wrap),
        .AtTerminal (at_terminal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clk_enable = 1'b0;
        clear      = 1'b0;
        load       = 1'b0;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        idle();
        load       = 1'b1;
        load_value = v;
        tick();
        load = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        up         = 1'b1;
        load_value = '0;
        idle();

        // Reset state
        #12;
        check("reset_count", 32'(count), 0);
        check("reset_wrap", 32'(wrap), 0);
        #1 rst = 1'b0;
        tick();
        check("post_reset_hold", 32'(count), 0);

        // Count up modulo 10: 1..9,0,1, Wrap only on the 9->0 step
        up         = 1'b1;
        clk_enable = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            if (k == 10) check("at_term_9_up", 32'(at_terminal), 1);
            tick();
            check($sformatf("up_count_%0d", k), 32'(count), 32'(k % 10));
            check($sformatf("up_wrap_%0d", k), 32'(wrap), (k == 10) ? 32'd1 : 32'd0);
        end

        // Synchronous clear
        idle();
        clear = 1'b1;
        tick();
        check("clear_count", 32'(count), 0);
        check("clear_wrap", 32'(wrap), 0);

        // Down step from 0
        idle();
        up         = 1'b0;
        clk_enable = 1'b1;
        tick();
`ifdef PARAM_COUNTER_SAT_EN
        check("down_from0_count", 32'(count), 0);
`else
        check("down_from0_count", 32'(count), 9);
`endif
        check("down_from0_wrap", 32'(wrap), 1);
        idle();
        tick();
        check("wrap_one_cycle", 32'(wrap), 0);

        // Out-of-range load clamps to MaxVal
        do_load(4'd14);
        check("load_clamp_count", 32'(count), 9);
        check("load_clamp_wrap", 32'(wrap), 0);

        // Clear beats Load
        clear      = 1'b1;
        load       = 1'b1;
        load_value = 4'd5;
        tick();
        check("clear_over_load", 32'(count), 0);

        // Load beats step at terminal; Wrap suppressed
        do_load(4'd9);
        up         = 1'b1;
        clk_enable = 1'b1;
        load       = 1'b1;
        load_value = 4'd3;
        tick();
        check("load_over_step_count", 32'(count), 3);
        check("load_over_step_wrap", 32'(wrap), 0);

        // Back-to-back steps from terminal
        do_load(4'd9);
        up         = 1'b1;
        clk_enable = 1'b1;
        tick();
`ifdef PARAM_COUNTER_SAT_EN
        check("term_step1_count", 32'(count), 9);
`else
        check("term_step1_count", 32'(count), 0);
`endif
        check("term_step1_wrap", 32'(wrap), 1);
        tick();
`ifdef PARAM_COUNTER_SAT_EN
        check("term_step2_count", 32'(count), 9);
        check("term_step2_wrap", 32'(wrap), 1);
`else
        check("term_step2_count", 32'(count), 1);
        check("term_step2_wrap", 32'(wrap), 0);
`endif

        // Asynchronous reset mid-cycle at Count=7
        do_load(4'd7);
        check("pre_reset_count", 32'(count), 7);
        #2 rst = 1'b1;
        #1;
        check("async_reset_count", 32'(count), 0);
        check("async_reset_wrap", 32'(wrap), 0);
        #1 rst = 1'b0;
        up         = 1'b1;
        clk_enable = 1'b1;
        tick();
        check("resume_after_reset", 32'(count), 1);
        check("resume_wrap", 32'(wrap), 0);

        // Hold with ClkEnable=0 for 5 edges at Count=5
        do_load(4'd5);
        idle();
        for (int k = 0; k < 5; k++) begin
            up = k[0];
            tick();
            check($sformatf("hold_count_%0d", k), 32'(count), 5);
            check($sformatf("hold_wrap_%0d", k), 32'(wrap), 0);
            check($sformatf("hold_at_term_%0d", k), 32'(at_terminal), 0);
        end

        // AtTerminal follows Up combinationally, no clock edge needed
        do_load(4'd9);
        up = 1'b1;
        #1 check("at_term_9_up_comb", 32'(at_terminal), 1);
        up = 1'b0;
        #1 check("at_term_9_down_comb", 32'(at_terminal), 0);
        do_load(4'd0);
        up = 1'b0;
        #1 check("at_term_0_down_comb", 32'(at_terminal), 1);
        up = 1'b1;
        #1 check("at_term_0_up_comb", 32'(at_terminal), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_param_counter
